// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: decodes sync / {R/W, addr} / data / trailer frames from the
// SPI slave byte engine into single-cycle register-bus write and read strobes.
// Read data is returned on tx_data within the same frame.
module spi_reg_bridge #(
    parameter logic [7:0] SYNC_BYTE   = 8'h89,
    parameter int         ABORT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs_active,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [7:0]             tx_data,
    output logic [6:0]             reg_addr,
    output logic [7:0]             reg_wdata,
    output logic                   reg_we,
    output logic                   reg_re,
    input  logic [7:0]             reg_rdata,
    output logic [ABORT_CNT_W-1:0] abort_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_addr_ld;
    logic                   w_we_set;
    logic                   w_re_set;
    logic                   w_abort;
    logic                   w_to_idle;

    logic                   r_wr;
    logic                   r_cap;
    logic                   r_we;
    logic                   r_re;
    logic [6:0]             r_addr;
    logic [7:0]             r_wdata;
    logic [7:0]             r_tx;
    logic [ABORT_CNT_W-1:0] r_abort;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(ABORT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state and strobe decode; a chip-select fall always beats a byte.
    always_comb begin
        w_next    = r_state;
        w_addr_ld = 1'b0;
        w_we_set  = 1'b0;
        w_re_set  = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cs_active && rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                if (!cs_active) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (rx_valid) begin
                    w_next    = DATA;
                    w_addr_ld = 1'b1;
                    w_re_set  = ~rx_data[7];
                end
            end
            DATA: begin
                if (!cs_active) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (rx_valid) begin
                    w_next   = TRAIL;
                    w_we_set = r_wr;
                end
            end
            TRAIL: begin
                // Read frames normally end here by chip-select falling.
                if (!cs_active || rx_valid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_to_idle = (r_state != IDLE) && (w_next == IDLE);

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus strobes, address/data latches, read-data return and abort counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_cap   <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_addr  <= 7'd0;
            r_wdata <= 8'd0;
            r_tx    <= 8'd0;
            r_abort <= '0;
        end else begin
            r_we  <= w_we_set;
            r_re  <= w_re_set;
            // reg_rdata is valid the cycle after reg_re, so capture one cycle later.
            r_cap <= r_re;
            if (w_addr_ld) begin
                r_addr <= rx_data[6:0];
                r_wr   <= rx_data[7];
            end
            if (w_we_set) begin
                r_wdata <= rx_data;
            end
            if (w_to_idle) begin
                r_tx <= 8'h00;
            end else if (r_cap && (r_state != IDLE)) begin
                r_tx <= reg_rdata;
            end
            if (w_abort) begin
                r_abort <= sat_inc(r_abort);
            end
        end
    end

    assign tx_data   = r_tx;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign abort_cnt = r_abort;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Testbench for spi_reg_bridge: table of frames plus hand-written corner cases,
// with a strobe scoreboard checked on every clock.
module tb_spi_reg_bridge;

    logic       clk;
    logic       rst;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] abort_cnt;

    spi_reg_bridge #(
        .SYNC_BYTE  (8'h89),
        .ABORT_CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_active(cs_active),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .abort_cnt(abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: read data appears the cycle after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } sb_t;

    typedef struct packed {
        logic [63:0] bytes;   // first byte in the top octet
        logic [3:0]  nb;
        logic        rd;
        logic        strobe;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  tx;
        logic [7:0]  acnt;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];
    sb_t  sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and score any strobe that appeared.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (reg_we && reg_re) check("we_re_exclusive", 32'(1), 32'(0));
        if (reg_we || reg_re) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, reg_we, reg_re}, 32'(0));
            end else begin
                e = sb.pop_front();
                check("sb_kind", 32'(reg_we), 32'(e.wr));
                check("sb_addr", 32'(reg_addr), 32'(e.addr));
                if (e.wr) check("sb_wdata", 32'(reg_wdata), 32'(e.data));
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic cs_drop();
        cs_active = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        cs_active = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;

        //            bytes                   nb    rd    stb   addr   wdata  tx     acnt
        tv[0]  = '{64'h89A4230000000000, 4'd4, 1'b0, 1'b1, 7'h24, 8'h23, 8'h00, 8'd0};
        tv[1]  = '{64'h8924000000000000, 4'd3, 1'b1, 1'b1, 7'h24, 8'h23, 8'h23, 8'd0};
        tv[2]  = '{64'h0055128985110000, 4'd7, 1'b0, 1'b1, 7'h05, 8'h11, 8'h00, 8'd0};
        tv[3]  = '{64'h8981000000000000, 4'd2, 1'b0, 1'b0, 7'h01, 8'h11, 8'h00, 8'd1};
        tv[4]  = '{64'h89815A0000000000, 4'd4, 1'b0, 1'b1, 7'h01, 8'h5A, 8'h00, 8'd1};
        tv[5]  = '{64'h8901000000000000, 4'd3, 1'b1, 1'b1, 7'h01, 8'h5A, 8'h5A, 8'd1};
        tv[6]  = '{64'h8905000000000000, 4'd3, 1'b1, 1'b1, 7'h05, 8'h5A, 8'h11, 8'd1};
        tv[7]  = '{64'h89FFC30000000000, 4'd4, 1'b0, 1'b1, 7'h7F, 8'hC3, 8'h00, 8'd1};
        tv[8]  = '{64'h897F000000000000, 4'd3, 1'b1, 1'b1, 7'h7F, 8'hC3, 8'hC3, 8'd1};
        tv[9]  = '{64'h8900000000000000, 4'd1, 1'b0, 1'b0, 7'h7F, 8'hC3, 8'h00, 8'd2};
        tv[10] = '{64'h8990000000000000, 4'd2, 1'b0, 1'b0, 7'h10, 8'hC3, 8'h00, 8'd3};

        tick();
        tick();
        check("rst_tx",    32'(tx_data),   32'(0));
        check("rst_addr",  32'(reg_addr),  32'(0));
        check("rst_wdata", 32'(reg_wdata), 32'(0));
        check("rst_we",    32'(reg_we),    32'(0));
        check("rst_re",    32'(reg_re),    32'(0));
        check("rst_abort", 32'(abort_cnt), 32'(0));
        rst = 1'b0;
        tick();

        // Table-driven frames.
        for (int i = 0; i < NV; i++) begin
            if (tv[i].strobe) sb.push_back('{wr: ~tv[i].rd, addr: tv[i].addr, data: tv[i].wdata});
            cs_active = 1'b1;
            tick();
            for (int k = 0; k < int'(tv[i].nb); k++) begin
                send(tv[i].bytes[63-8*k -: 8]);
                if (tv[i].rd && (k == int'(tv[i].nb) - 2)) check("vec_rd_tx", 32'(tx_data), 32'(tv[i].tx));
            end
            check("vec_addr",  32'(reg_addr),  32'(tv[i].addr));
            check("vec_wdata", 32'(reg_wdata), 32'(tv[i].wdata));
            cs_drop();
            check("vec_tx_idle", 32'(tx_data),   32'(0));
            check("vec_abort",   32'(abort_cnt), 32'(tv[i].acnt));
            check("vec_sb_empty", 32'(sb.size()), 32'(0));
        end

        // Write latency: reg_we exactly one cycle after the data byte.
        cs_active = 1'b1;
        tick();
        send(8'h89);
        send(8'h86);
        sb.push_back('{wr: 1'b1, addr: 7'h06, data: 8'h3C});
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        tick();
        check("we_lat", 32'(reg_we), 32'(1));
        rx_valid = 1'b0;
        tick();
        check("we_pulse", 32'(reg_we), 32'(0));
        send(8'h00);
        cs_drop();

        // Read latency: reg_re at N+1, tx_data valid from N+3.
        cs_active = 1'b1;
        tick();
        send(8'h89);
        sb.push_back('{wr: 1'b0, addr: 7'h24, data: 8'h00});
        rx_data  = 8'h24;
        rx_valid = 1'b1;
        tick();
        check("re_lat", 32'(reg_re), 32'(1));
        rx_valid = 1'b0;
        tick();
        check("re_pulse", 32'(reg_re), 32'(0));
        check("tx_early", 32'(tx_data), 32'(0));
        tick();
        check("tx_n3", 32'(tx_data), 32'(8'h23));
        send(8'h00);
        cs_drop();
        check("tx_after_cs", 32'(tx_data), 32'(0));

        // Chip-select fall coincident with the data byte: byte dropped, abort counted.
        cs_active = 1'b1;
        tick();
        send(8'h89);
        send(8'hA0);
        rx_data   = 8'h77;
        rx_valid  = 1'b1;
        cs_active = 1'b0;
        tick();
        rx_valid = 1'b0;
        check("coinc_abort", 32'(abort_cnt), 32'(4));
        tick();
        check("coinc_wdata", 32'(reg_wdata), 32'(8'h3C));

        // Back-to-back write frames with no idle cycles between bytes.
        sb.push_back('{wr: 1'b1, addr: 7'h21, data: 8'h01});
        sb.push_back('{wr: 1'b1, addr: 7'h22, data: 8'h02});
        cs_active = 1'b1;
        tick();
        begin
            logic [63:0] burst;
            burst = 64'h89A1010089A20200;
            for (int k = 0; k < 8; k++) begin
                rx_data  = burst[63-8*k -: 8];
                rx_valid = 1'b1;
                tick();
            end
        end
        rx_valid = 1'b0;
        tick();
        tick();
        check("b2b_addr",  32'(reg_addr),  32'(7'h22));
        check("b2b_wdata", 32'(reg_wdata), 32'(8'h02));
        check("b2b_sb_empty", 32'(sb.size()), 32'(0));
        cs_drop();
        check("b2b_abort", 32'(abort_cnt), 32'(4));

        // Bytes while chip select is low are ignored; sync must be seen with cs high.
        rx_data  = 8'h89;
        rx_valid = 1'b1;
        tick();
        cs_active = 1'b1;
        rx_data   = 8'h85;
        tick();
        rx_data = 8'h42;
        tick();
        rx_valid = 1'b0;
        tick();
        check("cs_low_addr", 32'(reg_addr), 32'(7'h22));
        cs_drop();
        check("cs_low_abort", 32'(abort_cnt), 32'(4));

        // 300 aborts saturate the counter.
        for (int n = 0; n < 300; n++) begin
            cs_active = 1'b1;
            rx_data   = 8'h89;
            rx_valid  = 1'b1;
            tick();
            rx_valid  = 1'b0;
            cs_active = 1'b0;
            tick();
            if (n == 100) check("abort_mid", 32'(abort_cnt), 32'(105));
        end
        tick();
        check("abort_sat", 32'(abort_cnt), 32'(255));

        // Reset between address and data bytes of a write.
        cs_active = 1'b1;
        tick();
        send(8'h89);
        send(8'hA7);
        rst = 1'b1;
        #1;
        check("mrst_tx",    32'(tx_data),   32'(0));
        check("mrst_addr",  32'(reg_addr),  32'(0));
        check("mrst_wdata", 32'(reg_wdata), 32'(0));
        check("mrst_we",    32'(reg_we),    32'(0));
        check("mrst_re",    32'(reg_re),    32'(0));
        check("mrst_abort", 32'(abort_cnt), 32'(0));
        tick();
        rst = 1'b0;
        send(8'h44);
        send(8'h00);
        check("mrst_left_wdata", 32'(reg_wdata), 32'(0));
        check("mrst_left_addr",  32'(reg_addr),  32'(0));
        cs_drop();
        check("mrst_abort_after", 32'(abort_cnt), 32'(0));
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level protocol decoder between the SPI slave byte engine and the internal 7-bit register bus in `top`. It parses host frames of the form sync / {R/W, addr} / data / trailer and issues single-cycle register write or read strobes. Read data is returned on the slave's transmit byte in the same frame. It is the only master of the register bus that configures the SD controller (clock divider, command, argument and reset registers).

## Interface
Parameters:
- `SYNC_BYTE`, default 8'h89: frame start byte.
- `ABORT_CNT_W`, default 8: width of the saturating abort counter.

Ports:
- `clk` in 1: system clock (SYSCLK domain); every input is synchronous to it.
- `rst` in 1: asynchronous, active-high reset.
- `cs_active` in 1: chip select, already synchronized to `clk`; 1 = frame in progress.
- `rx_valid` in 1: one-cycle pulse; `rx_data` holds a complete received byte.
- `rx_data` in 8: received byte.
- `tx_data` out 8: byte the slave shifts out next; the slave latches it on its own load strobe.
- `reg_addr` out 7: register address.
- `reg_wdata` out 8: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid the cycle after `reg_re`.
- `abort_cnt` out ABORT_CNT_W: saturating count of aborted frames.

## Operation
- States: IDLE, ADDR, DATA, TRAIL. Reset enters IDLE.
- IDLE:
  - `rx_valid` with `rx_data == SYNC_BYTE` goes to ADDR.
  - Any other byte is ignored and the state stays IDLE. This absorbs the leading 0x00 the host sends.
- ADDR, on `rx_valid`:
  - Latch `reg_addr = rx_data[6:0]` and `wr_flag = rx_data[7]`, then go to DATA.
  - If `wr_flag == 0`, issue `reg_re` for one cycle.
  - The following cycle, capture `reg_rdata` into `tx_data`.
- DATA, on `rx_valid`:
  - If `wr_flag == 1`: latch `reg_wdata = rx_data` and pulse `reg_we` for one cycle.
  - If `wr_flag == 0`: the byte is a dummy and no strobe is issued.
  - In both cases go to TRAIL.
- TRAIL:
  - Next `rx_valid` with any value goes to IDLE.
  - Read frames carry only 3 bytes, so a read frame normally ends by `cs_active` falling in TRAIL. This is not an abort.
- On entering IDLE, `tx_data` returns to 8'h00.
- Abort: `cs_active` falls while in ADDR or DATA.
  - Go to IDLE and issue no strobe.
  - `abort_cnt` increments and saturates at all-ones.
  - A fall in IDLE or TRAIL is not an abort.
- While `cs_active == 0`, `rx_valid` is ignored.
- Same-cycle `rx_valid` and `cs_active` fall: the fall wins, the byte is dropped, and the normal abort rule applies.
- `reg_we` and `reg_re` are never asserted in the same cycle.
- `reg_addr` and `reg_wdata` hold their values until the next frame overwrites them.
- Reset mid-frame: all state and outputs clear immediately; no strobe occurs.

## Timing
- Reset values:
  - state = IDLE
  - `tx_data` = 8'h00
  - `reg_addr` = 0
  - `reg_wdata` = 0
  - `reg_we` = 0
  - `reg_re` = 0
  - `abort_cnt` = 0
- Write latency: `rx_valid` (data byte) at cycle N, then `reg_we` = 1 at cycle N+1 with `reg_addr`/`reg_wdata` stable.
- Read latency, `rx_valid` (address byte) at cycle N:
  - `reg_re` = 1 at cycle N+1.
  - `reg_rdata` sampled at cycle N+2.
  - `tx_data` valid from cycle N+3.
- Slave contract: the tx load for the data byte must occur at least 3 `clk` cycles after the address-byte `rx_valid`. At SCLK ≤ SYSCLK/4 the inter-byte gap satisfies this.
- Back-to-back frames: a sync byte received the cycle after TRAIL completes starts a new frame. There are no dead cycles.
- `abort_cnt` updates in the cycle after the `cs_active` fall.

## Test plan
- Write frame 0x89, 0xA4, 0x23, 0x00: exactly one `reg_we` pulse with `reg_addr` = 0x24 and `reg_wdata` = 0x23; no `reg_re`; state returns to IDLE.
- Read frame 0x89, 0x24, 0x00 with the model returning 0x23: one `reg_re` with `reg_addr` = 0x24; `tx_data` = 0x23 within 3 cycles of the address byte; `tx_data` = 0x00 after `cs_active` falls; `abort_cnt` stays 0.
- Bytes 0x00, 0x55, 0x12 before sync, then a write frame 0x89, 0x85, 0x11, 0x00: the junk bytes cause no strobe; the write is to addr 0x05, data 0x11.
- `cs_active` falls after 0x89, 0x81: no strobe, `abort_cnt` = 1. A following full write to addr 0x01 executes normally.
- Fall coincident with the data-byte `rx_valid`: no `reg_we`, `abort_cnt` increments. 300 aborts saturate `abort_cnt` at 255.
- `rst` asserted between the address and data bytes of a write: all outputs are 0 immediately; the leftover data byte after reset is ignored; no `reg_we` occurs.
